// File: rtl/dcache_assoc_if.sv
// Load/store/flush request ports and TileLink-UL master port of dcache_assoc.
interface dcache_assoc_if;
  logic        ld_req_i;
  logic        ld_ready_o;
  logic [31:0] ld_addr_i;
  logic [1:0]  ld_size_i;
  logic        ld_uncached_i;
  logic        ld_valid_o;
  logic [31:0] ld_data_o;
  logic        ld_err_o;
  logic        st_valid_i;
  logic [29:0] st_addr_i;
  logic [31:0] st_data_i;
  logic [3:0]  st_bm_i;
  logic        st_done_o;
  logic        flush_req_i;
  logic        flush_done_o;
  logic [2:0]  a_opcode_o;
  logic [2:0]  a_param_o;
  logic [3:0]  a_size_o;
  logic [31:0] a_address_o;
  logic [3:0]  a_mask_o;
  logic [31:0] a_data_o;
  logic        a_valid_o;
  logic        a_ready_i;
  logic [2:0]  d_opcode_i;
  logic [3:0]  d_size_i;
  logic        d_denied_i;
  logic [31:0] d_data_i;
  logic        d_valid_i;
  logic        d_ready_o;

  // Cache side.
  modport master (
    input  ld_req_i, ld_addr_i, ld_size_i, ld_uncached_i,
    output ld_ready_o, ld_valid_o, ld_data_o, ld_err_o,
    input  st_valid_i, st_addr_i, st_data_i, st_bm_i,
    output st_done_o,
    input  flush_req_i,
    output flush_done_o,
    output a_opcode_o, a_param_o, a_size_o, a_address_o, a_mask_o, a_data_o, a_valid_o,
    input  a_ready_i,
    input  d_opcode_i, d_size_i, d_denied_i, d_data_i, d_valid_i,
    output d_ready_o
  );

  // Load/store units and TileLink slave side.
  modport slave (
    output ld_req_i, ld_addr_i, ld_size_i, ld_uncached_i,
    input  ld_ready_o, ld_valid_o, ld_data_o, ld_err_o,
    output st_valid_i, st_addr_i, st_data_i, st_bm_i,
    input  st_done_o,
    output flush_req_i,
    input  flush_done_o,
    input  a_opcode_o, a_param_o, a_size_o, a_address_o, a_mask_o, a_data_o, a_valid_o,
    output a_ready_i,
    output d_opcode_i, d_size_i, d_denied_i, d_data_i, d_valid_i,
    input  d_ready_o
  );
endinterface

// File: rtl/dcache_assoc.sv
// Set-associative write-through, no-write-allocate L1 data cache with a TL-UL master port.
module dcache_assoc #(
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS       = 32,
  parameter int unsigned LINE_BYTES = 128
) (
  input  logic           cpu_clock_i,
  input  logic           cpu_reset_i,
  dcache_assoc_if.master bus
);
  localparam int unsigned BEATS  = LINE_BYTES / 4;
  localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned BEAT_W = OFF_W - 2;
  localparam int unsigned TAG_LO = OFF_W + IDX_W;
  localparam int unsigned TAG_W  = 31 - TAG_LO;
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned DEPTH  = WAYS * SETS * BEATS;
  localparam int unsigned MEM_AW = $clog2(DEPTH);

  localparam logic [2:0] TL_PUT_FULL    = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] TL_GET         = 3'd4;
  localparam logic [2:0] TL_ACK         = 3'd0;
  localparam logic [2:0] TL_ACK_DATA    = 3'd1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_REFILL, S_UNC, S_STORE, S_FLUSH
  } state_t;

  state_t                  state_q;
  logic [TAG_W-1:0]        tag_q   [WAYS][SETS];
  logic [SETS-1:0]         valid_q [WAYS];
  logic [WAY_W-1:0]        rr_q    [SETS];
  logic [30:2]             req_addr_q;
  logic [WAY_W-1:0]        victim_q;
  logic [BEAT_W-1:0]       beat_q;
  logic                    denied_q;
  logic [IDX_W-1:0]        flush_idx_q;

  logic                    ld_valid_q, ld_err_q, ld_from_mem_q, st_done_q, flush_done_q;
  logic [31:0]             ld_data_q;
  logic [2:0]              a_opcode_q;
  logic [3:0]              a_size_q, a_mask_q;
  logic [31:0]             a_address_q, a_data_q;
  logic                    a_valid_q;

  logic [31:0]             mem_q [DEPTH];
  logic [31:0]             rd_data_q;
  logic [3:0]              mem_be;
  logic [MEM_AW-1:0]       mem_waddr, mem_raddr;
  logic [31:0]             mem_wdata;

  logic [IDX_W-1:0]        ld_idx, st_idx;
  logic [TAG_W-1:0]        ld_tag, st_tag;
  logic [BEAT_W-1:0]       ld_word, st_word;
  logic                    ld_hit, st_hit, victim_found;
  logic [WAY_W-1:0]        ld_hit_way, st_hit_way, victim;
  logic                    st_cacheable, flush_go, store_go, ld_go, ld_rdy;
  logic [2:0]              st_op;
  logic [3:0]              st_size;
  logic [1:0]              st_off;
  logic                    unused_d_size;

  function automatic logic [MEM_AW-1:0] mem_index(input logic [WAY_W-1:0] w,
                                                  input logic [IDX_W-1:0] s,
                                                  input logic [BEAT_W-1:0] b);
    return MEM_AW'((int'(w) * SETS + int'(s)) * BEATS + int'(b));
  endfunction

  assign ld_idx       = req_addr_q[OFF_W +: IDX_W];
  assign ld_tag       = req_addr_q[30:TAG_LO];
  assign ld_word      = req_addr_q[2 +: BEAT_W];
  assign st_idx       = bus.st_addr_i[OFF_W-2 +: IDX_W];
  assign st_tag       = bus.st_addr_i[29:TAG_LO-2];
  assign st_word      = bus.st_addr_i[0 +: BEAT_W];
  assign st_cacheable = !bus.st_addr_i[29];
  assign unused_d_size = ^bus.d_size_i;

  // A request or flush still showing its done pulse is the old one, not a new one.
  assign flush_go = (state_q == S_IDLE) && bus.flush_req_i && !flush_done_q;
  assign store_go = (state_q == S_IDLE) && !flush_go && bus.st_valid_i && !st_done_q;
  assign ld_rdy   = (state_q == S_IDLE) && !cpu_reset_i
                 && !(bus.flush_req_i && !flush_done_q) && !(bus.st_valid_i && !st_done_q);
  assign ld_go    = bus.ld_req_i && ld_rdy;

  always_comb begin
    ld_hit       = 1'b0;
    ld_hit_way   = '0;
    st_hit       = 1'b0;
    st_hit_way   = '0;
    victim_found = 1'b0;
    victim       = rr_q[ld_idx];
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[w][ld_idx] && tag_q[w][ld_idx] == ld_tag) begin
        ld_hit     = 1'b1;
        ld_hit_way = WAY_W'(w);
      end
      if (valid_q[w][st_idx] && tag_q[w][st_idx] == st_tag) begin
        st_hit     = 1'b1;
        st_hit_way = WAY_W'(w);
      end
      if (!victim_found && !valid_q[w][ld_idx]) begin
        victim_found = 1'b1;
        victim       = WAY_W'(w);
      end
    end
  end

  always_comb begin
    st_op   = TL_PUT_PARTIAL;
    st_size = 4'd2;
    st_off  = 2'd0;
    case (bus.st_bm_i)
      4'b1111: st_op = TL_PUT_FULL;
      4'b0011: begin st_op = TL_PUT_FULL; st_size = 4'd1; st_off = 2'd0; end
      4'b1100: begin st_op = TL_PUT_FULL; st_size = 4'd1; st_off = 2'd2; end
      4'b0001: begin st_op = TL_PUT_FULL; st_size = 4'd0; st_off = 2'd0; end
      4'b0010: begin st_op = TL_PUT_FULL; st_size = 4'd0; st_off = 2'd1; end
      4'b0100: begin st_op = TL_PUT_FULL; st_size = 4'd0; st_off = 2'd2; end
      4'b1000: begin st_op = TL_PUT_FULL; st_size = 4'd0; st_off = 2'd3; end
      default: ;
    endcase
  end

  always_comb begin
    mem_be    = '0;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_raddr = mem_index(ld_hit_way, ld_idx, ld_word);
    if (store_go && st_cacheable && st_hit) begin
      mem_be    = bus.st_bm_i;
      mem_waddr = mem_index(st_hit_way, st_idx, st_word);
      mem_wdata = bus.st_data_i;
    end else if (state_q == S_REFILL && bus.d_valid_i && bus.d_opcode_i == TL_ACK_DATA) begin
      mem_be    = '1;
      mem_waddr = mem_index(victim_q, ld_idx, beat_q);
      mem_wdata = bus.d_data_i;
    end
  end

  always_ff @(posedge cpu_clock_i) begin
    for (int unsigned b = 0; b < 4; b++)
      if (mem_be[b]) mem_q[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
    rd_data_q <= mem_q[mem_raddr];
  end

  always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
    if (cpu_reset_i) begin
      state_q       <= S_IDLE;
      for (int unsigned w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        for (int unsigned s = 0; s < SETS; s++) tag_q[w][s] <= '0;
      end
      for (int unsigned s = 0; s < SETS; s++) rr_q[s] <= '0;
      req_addr_q    <= '0;
      victim_q      <= '0;
      beat_q        <= '0;
      denied_q      <= 1'b0;
      flush_idx_q   <= '0;
      ld_valid_q    <= 1'b0;
      ld_err_q      <= 1'b0;
      ld_from_mem_q <= 1'b0;
      ld_data_q     <= '0;
      st_done_q     <= 1'b0;
      flush_done_q  <= 1'b0;
      a_opcode_q    <= '0;
      a_size_q      <= '0;
      a_mask_q      <= '0;
      a_address_q   <= '0;
      a_data_q      <= '0;
      a_valid_q     <= 1'b0;
    end else begin
      ld_valid_q    <= 1'b0;
      ld_err_q      <= 1'b0;
      ld_from_mem_q <= 1'b0;
      st_done_q     <= 1'b0;
      flush_done_q  <= 1'b0;
      if (a_valid_q && bus.a_ready_i) a_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (flush_go) begin
            for (int unsigned w = 0; w < WAYS; w++) valid_q[w][0] <= 1'b0;
            flush_idx_q <= IDX_W'(1);
            state_q     <= S_FLUSH;
          end else if (store_go) begin
            a_valid_q   <= 1'b1;
            a_opcode_q  <= st_op;
            a_size_q    <= st_size;
            a_address_q <= {bus.st_addr_i, st_off};
            a_mask_q    <= bus.st_bm_i;
            a_data_q    <= bus.st_data_i;
            state_q     <= S_STORE;
          end else if (ld_go) begin
            req_addr_q <= bus.ld_addr_i[30:2];
            if (bus.ld_addr_i[31] || bus.ld_uncached_i) begin
              a_valid_q   <= 1'b1;
              a_opcode_q  <= TL_GET;
              a_size_q    <= {2'b00, bus.ld_size_i};
              a_address_q <= bus.ld_addr_i;
              a_mask_q    <= 4'hF;
              a_data_q    <= '0;
              state_q     <= S_UNC;
            end else begin
              state_q <= S_LOOKUP;
            end
          end
        end
        S_LOOKUP: begin
          if (ld_hit) begin
            ld_valid_q    <= 1'b1;
            ld_from_mem_q <= 1'b1;
            state_q       <= S_IDLE;
          end else begin
            victim_q                <= victim;
            valid_q[victim][ld_idx] <= 1'b0;
            a_valid_q               <= 1'b1;
            a_opcode_q              <= TL_GET;
            a_size_q                <= 4'(OFF_W);
            a_address_q             <= {1'b0, req_addr_q[30:OFF_W], {OFF_W{1'b0}}};
            a_mask_q                <= 4'hF;
            a_data_q                <= '0;
            beat_q                  <= '0;
            denied_q                <= 1'b0;
            state_q                 <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (bus.d_valid_i && bus.d_opcode_i == TL_ACK_DATA) begin
            beat_q   <= beat_q + 1'b1;
            denied_q <= denied_q | bus.d_denied_i;
            if (beat_q == ld_word) ld_data_q <= bus.d_data_i;
            if (beat_q == BEAT_W'(BEATS - 1)) begin
              if (!(denied_q || bus.d_denied_i)) begin
                valid_q[victim_q][ld_idx] <= 1'b1;
                tag_q[victim_q][ld_idx]   <= ld_tag;
                rr_q[ld_idx]              <= WAY_W'((int'(rr_q[ld_idx]) + 1) % WAYS);
              end
              ld_valid_q <= 1'b1;
              ld_err_q   <= denied_q | bus.d_denied_i;
              state_q    <= S_IDLE;
            end
          end
        end
        S_UNC: begin
          if (bus.d_valid_i && bus.d_opcode_i == TL_ACK_DATA) begin
            ld_valid_q <= 1'b1;
            ld_data_q  <= bus.d_data_i;
            ld_err_q   <= bus.d_denied_i;
            state_q    <= S_IDLE;
          end
        end
        S_STORE: begin
          if (bus.d_valid_i && bus.d_opcode_i == TL_ACK) begin
            st_done_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        S_FLUSH: begin
          for (int unsigned w = 0; w < WAYS; w++) valid_q[w][flush_idx_q] <= 1'b0;
          flush_idx_q <= flush_idx_q + 1'b1;
          if (flush_idx_q == IDX_W'(SETS - 1)) begin
            flush_done_q <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ld_ready_o   = ld_rdy;
  assign bus.ld_valid_o   = ld_valid_q;
  assign bus.ld_data_o    = ld_from_mem_q ? rd_data_q : ld_data_q;
  assign bus.ld_err_o     = ld_err_q;
  assign bus.st_done_o    = st_done_q;
  assign bus.flush_done_o = flush_done_q;
  assign bus.a_opcode_o   = a_opcode_q;
  assign bus.a_param_o    = '0;
  assign bus.a_size_o     = a_size_q;
  assign bus.a_address_o  = a_address_q;
  assign bus.a_mask_o     = a_mask_q;
  assign bus.a_data_o     = a_data_q;
  assign bus.a_valid_o    = a_valid_q;
  assign bus.d_ready_o    = 1'b1;
endmodule

// File: tb/tb_dcache_assoc.sv
// Scoreboard bench for dcache_assoc: directed loads, stores, flush and reset with hand-computed expectations.
module tb_dcache_assoc;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_assoc_if bus();
  dcache_assoc #(.WAYS(2), .SETS(32), .LINE_BYTES(128)) dut (
    .cpu_clock_i(clk), .cpu_reset_i(rst), .bus(bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  size;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } a_exp_t;
  typedef struct {
    logic [31:0] data;
    logic        err;
  } ld_exp_t;

  a_exp_t  a_q[$];
  ld_exp_t ld_q[$];
  a_exp_t  ae;
  ld_exp_t le;
  int n_tests = 0, n_fail = 0;
  int a_seen = 0, ld_seen = 0, st_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an A request or a load response.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.a_valid_o && bus.a_ready_i) begin
        a_seen++;
        if (a_q.size() == 0) check("a_unexpected", bus.a_address_o, 32'hFFFF_FFFF);
        else begin
          ae = a_q.pop_front();
          check("a_opcode", 32'(bus.a_opcode_o), 32'(ae.op));
          check("a_param", 32'(bus.a_param_o), 32'd0);
          check("a_size", 32'(bus.a_size_o), 32'(ae.size));
          check("a_address", bus.a_address_o, ae.addr);
          check("a_mask", 32'(bus.a_mask_o), 32'(ae.mask));
          if (ae.op != 3'd4) check("a_data", bus.a_data_o, ae.data);
        end
      end
      if (bus.ld_valid_o) begin
        ld_seen++;
        if (ld_q.size() == 0) check("ld_unexpected", bus.ld_data_o, 32'hFFFF_FFFF);
        else begin
          le = ld_q.pop_front();
          check("ld_data", bus.ld_data_o, le.data);
          check("ld_err", 32'(bus.ld_err_o), 32'(le.err));
        end
      end
      if (bus.st_done_o) st_seen++;
    end
  end

  task automatic wait_a(input int prev);
    for (int i = 0; i < 100 && a_seen == prev; i++) @(posedge clk);
    check("a_timeout", 32'(a_seen != prev), 32'd1);
  endtask

  task automatic wait_ld(input int prev);
    for (int i = 0; i < 100 && ld_seen == prev; i++) @(posedge clk);
    check("ld_timeout", 32'(ld_seen != prev), 32'd1);
  endtask

  task automatic send_beats(input int n, input logic [31:0] base, input int deny);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.d_valid_i  = 1'b1;
      bus.d_opcode_i = 3'd1;
      bus.d_data_i   = base + 32'(k);
      bus.d_denied_i = (k == deny);
    end
    @(negedge clk);
    bus.d_valid_i  = 1'b0;
    bus.d_denied_i = 1'b0;
  endtask

  task automatic accept(input logic [31:0] addr, input logic unc, input logic [1:0] size);
    logic acc;
    acc = 1'b0;
    @(negedge clk);
    bus.ld_req_i = 1'b1; bus.ld_addr_i = addr; bus.ld_uncached_i = unc; bus.ld_size_i = size;
    for (int i = 0; i < 100 && !acc; i++) begin
      #1 acc = bus.ld_ready_o;
      @(posedge clk);
    end
    check("accept_timeout", 32'(acc), 32'd1);
    #1 bus.ld_req_i = 1'b0; bus.ld_uncached_i = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] addr, input logic unc, input logic [1:0] size,
                         input logic miss, input logic [31:0] a_addr, input logic [3:0] a_size,
                         input int nbeats, input logic [31:0] base, input int deny,
                         input logic [31:0] exp_data, input logic exp_err, input int stall);
    int a0, l0, lat;
    a0 = a_seen; l0 = ld_seen;
    if (miss) a_q.push_back('{op: 3'd4, size: a_size, addr: a_addr, mask: 4'hF, data: 32'd0});
    ld_q.push_back('{data: exp_data, err: exp_err});
    if (stall > 0) bus.a_ready_i = 1'b0;
    accept(addr, unc, size);
    if (!miss) begin
      lat = 0;
      for (int i = 0; i < 10 && lat == 0; i++) begin
        @(negedge clk);
        if (bus.ld_valid_o) lat = i + 1;
      end
      check("hit_latency", 32'(lat), 32'd2);
      @(posedge clk);
      check("hit_no_a", 32'(a_seen - a0), 32'd0);
    end else begin
      if (stall > 0) begin
        repeat (stall) @(negedge clk);
        check("a_held", 32'(bus.a_valid_o), 32'd1);
        bus.a_ready_i = 1'b1;
      end
      wait_a(a0);
      send_beats(nbeats, base, deny);
    end
    wait_ld(l0);
  endtask

  task automatic do_store(input logic [29:0] waddr, input logic [31:0] data, input logic [3:0] bm,
                          input logic [2:0] op, input logic [3:0] size, input logic [31:0] a_addr);
    int a0, s0;
    a0 = a_seen; s0 = st_seen;
    a_q.push_back('{op: op, size: size, addr: a_addr, mask: bm, data: data});
    @(negedge clk);
    bus.st_valid_i = 1'b1; bus.st_addr_i = waddr; bus.st_data_i = data; bus.st_bm_i = bm;
    wait_a(a0);
    @(negedge clk);
    bus.d_valid_i = 1'b1; bus.d_opcode_i = 3'd0; bus.d_denied_i = 1'b0;
    @(posedge clk);
    #1 bus.d_valid_i = 1'b0;
    for (int i = 0; i < 100 && st_seen == s0; i++) @(posedge clk);
    #1 bus.st_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    check("st_done_pulses", 32'(st_seen - s0), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, l0;
    logic done;
    rst = 1'b1;
    bus.ld_req_i = 0; bus.ld_addr_i = 0; bus.ld_size_i = 0; bus.ld_uncached_i = 0;
    bus.st_valid_i = 0; bus.st_addr_i = 0; bus.st_data_i = 0; bus.st_bm_i = 0;
    bus.flush_req_i = 0; bus.a_ready_i = 1'b1;
    bus.d_opcode_i = 0; bus.d_size_i = 0; bus.d_denied_i = 0; bus.d_data_i = 0; bus.d_valid_i = 0;
    repeat (3) @(negedge clk);
    check("rst_ld_ready", 32'(bus.ld_ready_o), 32'd0);
    check("rst_a_valid", 32'(bus.a_valid_o), 32'd0);
    check("rst_d_ready", 32'(bus.d_ready_o), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ld_ready", 32'(bus.ld_ready_o), 32'd1);

    // Cold miss with A stalled, then a hit; 0x1084 is set 1, word 1.
    do_load(32'h0000_1084, 0, 2'd2, 1, 32'h0000_1080, 4'd7, 32, 32'h0, -1, 32'h1, 0, 3);
    do_load(32'h0000_1084, 0, 2'd2, 0, 0, 0, 0, 0, -1, 32'h1, 0, 0);
    // Round-robin in set 1.
    do_load(32'h0000_2080, 0, 2'd2, 1, 32'h0000_2080, 4'd7, 32, 32'h2000_0000, -1, 32'h2000_0000, 0, 0);
    do_load(32'h0000_3088, 0, 2'd2, 1, 32'h0000_3080, 4'd7, 32, 32'h3000_0000, -1, 32'h3000_0002, 0, 0);
    do_load(32'h0000_2084, 0, 2'd2, 0, 0, 0, 0, 0, -1, 32'h2000_0001, 0, 0);
    do_load(32'h0000_1084, 0, 2'd2, 1, 32'h0000_1080, 4'd7, 32, 32'h0, -1, 32'h1, 0, 0);

    // Stores into the cached 0x1084 line.
    do_store(30'h421, 32'hAABB_CCDD, 4'b0100, 3'd0, 4'd0, 32'h0000_1086);
    do_load(32'h0000_1084, 0, 2'd2, 0, 0, 0, 0, 0, -1, 32'h00BB_0001, 0, 0);
    do_store(30'h421, 32'h1122_3344, 4'b0101, 3'd1, 4'd2, 32'h0000_1084);
    do_load(32'h0000_1084, 0, 2'd2, 0, 0, 0, 0, 0, -1, 32'h0022_0044, 0, 0);
    do_store(30'h422, 32'hCAFE_0000, 4'b1100, 3'd0, 4'd1, 32'h0000_108A);
    do_load(32'h0000_1088, 0, 2'd2, 0, 0, 0, 0, 0, -1, 32'hCAFE_0002, 0, 0);

    // Uncached: I/O space and forced.
    do_load(32'h8000_0010, 0, 2'd2, 1, 32'h8000_0010, 4'd2, 1, 32'h1234_5678, -1, 32'h1234_5678, 0, 0);
    do_load(32'h0000_1084, 1, 2'd0, 1, 32'h0000_1084, 4'd0, 1, 32'hDEAD_BEEF, -1, 32'hDEAD_BEEF, 0, 0);
    do_load(32'h0000_1084, 0, 2'd2, 0, 0, 0, 0, 0, -1, 32'h0022_0044, 0, 0);

    // Denied beat 5 leaves the line invalid.
    do_load(32'h0000_4100, 0, 2'd2, 1, 32'h0000_4100, 4'd7, 32, 32'h4000_0000, 5, 32'h4000_0000, 1, 0);
    do_load(32'h0000_4100, 0, 2'd2, 1, 32'h0000_4100, 4'd7, 32, 32'h4000_0000, -1, 32'h4000_0000, 0, 0);

    // Flush: done 32 cycles after the request.
    @(negedge clk);
    bus.flush_req_i = 1'b1;
    n = 0; done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      n++;
      done = bus.flush_done_o;
    end
    bus.flush_req_i = 1'b0;
    check("flush_cycles", 32'(n), 32'd32);
    do_load(32'h0000_1084, 0, 2'd2, 1, 32'h0000_1080, 4'd7, 32, 32'h10, -1, 32'h11, 0, 0);
    do_load(32'h0000_3088, 0, 2'd2, 1, 32'h0000_3080, 4'd7, 32, 32'h50, -1, 32'h52, 0, 0);

    // Reset in the middle of a refill; later beats must be ignored.
    a_q.push_back('{op: 3'd4, size: 4'd7, addr: 32'h0000_6000, mask: 4'hF, data: 32'd0});
    n = a_seen;
    accept(32'h0000_6000, 0, 2'd2);
    wait_a(n);
    send_beats(3, 32'h6000_0000, -1);
    rst = 1'b1;
    #1;
    check("mid_rst_ld_valid", 32'(bus.ld_valid_o), 32'd0);
    check("mid_rst_ld_data", bus.ld_data_o, 32'd0);
    check("mid_rst_ld_ready", 32'(bus.ld_ready_o), 32'd0);
    check("mid_rst_a_valid", 32'(bus.a_valid_o), 32'd0);
    check("mid_rst_a_address", bus.a_address_o, 32'd0);
    check("mid_rst_flush_done", 32'(bus.flush_done_o), 32'd0);
    check("mid_rst_d_ready", 32'(bus.d_ready_o), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    l0 = ld_seen;
    send_beats(29, 32'h6000_0003, -1);
    repeat (3) @(posedge clk);
    check("stray_beats_ignored", 32'(ld_seen - l0), 32'd0);
    do_load(32'h0000_1084, 0, 2'd2, 1, 32'h0000_1080, 4'd7, 32, 32'h100, -1, 32'h101, 0, 0);

    repeat (3) @(posedge clk);
    check("a_queue_empty", 32'(a_q.size()), 32'd0);
    check("ld_queue_empty", 32'(ld_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dcache_assoc.md
Name: dcache_assoc

Overview:
- Parametrised set-associative, write-through, no-write-allocate L1 data cache; successor to the fixed 2-way/32-set dcache.
- Sits between the load/store units and a single TileLink-UL master port.
- Adds configurable ways, sets and line size, per-set round-robin replacement, bus-error reporting and a full-cache invalidate (flush).
- Address bit 31 set = I/O space, always uncached.

Parameters:
WAYS, 2, associativity (power of 2, 1..8)
SETS, 32, number of sets (power of 2, >=2)
LINE_BYTES, 128, line size in bytes (power of 2, 8..256); refill beats BEATS=LINE_BYTES/4

Ports:
cpu_clock_i  in  1  clock
cpu_reset_i  in  1  asynchronous active-high reset
ld_req_i  in  1  load request
ld_ready_o  out  1  load accepted when ld_req_i&ld_ready_o
ld_addr_i  in  32  load byte address
ld_size_i  in  2  log2 bytes, used for uncached Get
ld_uncached_i  in  1  force uncached
ld_valid_o  out  1  one-cycle pulse, ld_data_o valid
ld_data_o  out  32  aligned 32-bit word containing the load
ld_err_o  out  1  qualifies ld_valid_o, d_denied seen
st_valid_i  in  1  store request, held until st_done_o
st_addr_i  in  30  word address
st_data_i  in  32  store data, byte lanes aligned
st_bm_i  in  4  byte mask, nonzero
st_done_o  out  1  one-cycle pulse on store AccessAck
flush_req_i  in  1  invalidate all lines, held until flush_done_o
flush_done_o  out  1  one-cycle pulse
a_opcode_o/a_param_o/a_size_o/a_address_o/a_mask_o/a_data_o/a_valid_o  out  3/3/4/32/4/32/1  TL-UL A
a_ready_i  in  1
d_opcode_i/d_size_i/d_denied_i/d_data_i/d_valid_i  in  3/4/1/32/1  TL-UL D
d_ready_o  out  1  tied 1

Behaviour:
- Reset: all valid bits 0, round-robin pointers 0, FSM IDLE; all outputs 0 except d_ready_o=1. Reset mid-transaction abandons it; D beats arriving in IDLE are discarded.
- Geometry: offset=addr[log2(LINE_BYTES)-1:0], index=next log2(SETS) bits, tag=addr[30:index_top+1]. Tag and valid arrays are flops; data array is one 32-bit-wide memory of WAYS*SETS*BEATS words, one read and one byte-masked write port, registered read.
- IDLE priority: flush > store > load. ld_ready_o=1 only in IDLE with no flush/store pending.
- LOOKUP (1 cycle after acceptance): compare all ways. Hit and cacheable -> ld_valid_o in the next cycle (latency 2 from acceptance), FSM back to IDLE.
- Miss, cacheable: victim = first invalid way (lowest index), else rr[set]. Clear victim valid, issue Get address line-aligned, size log2(LINE_BYTES), mask 4'hF.
- REFILL: A held valid until a_ready_i. Each D beat k writes word k of the victim line. At the last beat (BEATS-th), if no beat was denied, set tag and valid and advance rr[set] (mod WAYS); assert ld_valid_o with the requested word captured during refill. If any beat was denied: line stays invalid, ld_err_o=1 with ld_valid_o.
- Uncached (bit31|ld_uncached_i): Get with exact address and size ld_size_i, mask 4'hF. First D beat gives ld_valid_o, ld_data_o=d_data_i, ld_err_o=d_denied_i. No array change.
- STORE: address {st_addr_i,2'b00} adjusted to the lowest set byte.
  - Mask 4'hF -> PutFullData (0), size 2.
  - Contiguous aligned 2-byte or 1-byte mask -> PutFullData with size 1 or 0.
  - Otherwise PutPartialData (1), size 2, address word-aligned, mask=st_bm_i.
  - Hit (tag check at issue) writes the masked bytes into the data array the cycle A is issued. Miss does not allocate.
  - st_done_o on the AccessAck beat.
- FLUSH: clear one set's valids per cycle, SETS cycles, then flush_done_o. rr pointers are kept.
- Simultaneous load hit and refill write to the same set are impossible: single FSM.

Test Plan:
- Defaults, cold load 0x0000_1084 -> Get addr 0x0000_1080 size 7; 32 D beats with data=beat index; ld_valid_o after the last beat, ld_data_o=1. Repeat load -> ld_valid_o 2 cycles after accept, no A traffic.
- Fill 3 distinct tags into set 1 -> third fill evicts way 0 (rr); reload of the first tag misses, reload of the second tag hits.
- Store bm=4'b0100, data 0xAABBCCDD, to a cached word -> PutFullData size 0 addr+2; a later load returns the byte 0xBB updated, others unchanged. bm=4'b0101 -> PutPartialData mask 0x5.
- Load 0x8000_0010 size 2 -> Get exact address; D data 0x12345678 -> ld_data_o=0x12345678, no cache fill.
- Refill with beat 5 denied -> ld_err_o=1; reload misses again.
- Flush with SETS=32 -> flush_done_o 32 cycles after start; all subsequent loads miss. Assert cpu_reset_i mid-refill -> all outputs at reset values, stray D beats ignored.
